score_collector: RTL and testbench
==================================

# score_collector

Parametrised result collector behind a scoring bank's result ports: `results`, `IDs` and `vld` across `CHANNELS` slots.
- Captures each new valid result exactly once and unbiases the score.
- Arbitrates round-robin into a show-ahead FIFO with valid/ready output.
- Tracks the per-query maximum and counts every result seen.
- Replaces bench-side dedup bitmaps; it is the bank's host-facing result path.

## Interface
- `SCORE_WIDTH`, 12: result width, biased encoding.
- `ID_WIDTH`, 48: sequence ID width.
- `CHANNELS`, 8: number of result slots (2×modules per bank); ≥2.
- `DEPTH`, 16: FIFO entries, power of two, ≥2.
- `CNT_WIDTH`, 16: result counter width.
- `ZERO`, 2**(SCORE_WIDTH-1): score bias.
- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock, asynchronous, active-low.
- `clr`  in  1  synchronous per-query clear.
- `threshold`  in  SCORE_WIDTH  signed unbiased forwarding threshold.
- `results`  in  [0:CHANNELS*SCORE_WIDTH-1]  biased scores, channel 0 in bits [0:SCORE_WIDTH-1].
- `IDs`  in  [0:CHANNELS*ID_WIDTH-1]  IDs, same slicing.
- `vld`  in  [0:CHANNELS-1]  level valid per channel.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accept.
- `out_id`  out  ID_WIDTH  head ID.
- `out_score`  out  SCORE_WIDTH  head score, signed, unbiased.
- `max_score`  out  SCORE_WIDTH  signed unbiased running maximum.
- `max_id`  out  ID_WIDTH  ID of max.
- `max_vld`  out  1  max holds at least one result.
- `count`  out  CNT_WIDTH  results granted since clear; saturating.
- `overrun`  out  1  sticky: a result was lost.

## Operation
- **Per-channel state:** `armed`, `pending`, and a holding register (score, id).
- **Capture:** if `vld[c]`, `armed[c]` and `!pending[c]`, latch the slot, set `pending`, clear `armed`. `armed[c]` sets when `vld[c]` is sampled 0.
- **Deferred capture:** a new `vld` rise while `pending[c]` is deferred while `vld` stays high.
- **Overrun:** if `vld[c]` falls while still un-captured, set `overrun`; the result is lost.
- **Arbiter:** grants at most one pending channel per cycle, round-robin. Search starts at last grant +1, mod `CHANNELS`. After reset or `clr`, search starts at channel 0.
- **Stall:** no grant while the FIFO is full, using registered full.
- **Granted entry:**
  - `pending` clears.
  - `count` increments, saturating at all-ones.
  - max updates if score > `max_score` or `!max_vld`; ties keep the earlier result.
  - If score ≥ `threshold` (signed compare), push {id, score−ZERO}; otherwise drop silently.
- **Unbiasing:** score−ZERO in SCORE_WIDTH bits is reinterpreted as signed; no width growth.
- **FIFO:** show-ahead. `out_valid` = !empty. A pop occurs on `out_valid && out_ready`.
- **`clr`:**
  - Empties the FIFO and clears `pending`, `max_vld`, `max_score`, `max_id`, `count`, `overrun` and the round-robin pointer.
  - Sets `armed[c]` = !`vld[c]`, so results still held from the previous query are not recaptured.
  - `clr` overrides same-cycle capture, grant and pop.
- **Reset values:** all outputs 0; `armed` all 1; FIFO empty.

## Timing
- `vld[c]` rise sampled at edge k: capture at k, grant and push at k+1, `out_valid` high after k+1. Minimum latency is 2 cycles.
- Simultaneous pop and grant when not full: both occur; occupancy unchanged.
- Pop on a full FIFO frees a slot; the grant happens the next cycle (1-cycle bubble, accepted).
- `out_*` hold stable while `out_valid && !out_ready`.
- `max_*` and `count` update the cycle after the grant edge.
- Mid-operation `rst`: asynchronous return to reset values; in-flight results are discarded.
- Sustained throughput: 1 result per cycle.

## Structure
- Package `sw_pkg`: the `ZERO` bias, an unbias function, and a `result_t` struct {id, score}. Shared with the scoring modules and the bank.
- One sub-module, `score_fifo` (parameters DEPTH and width; show-ahead; full/empty flags; sync flush input driven by `clr`).
- The arbiter and capture logic stay inline.

## Test plan
- **Single result:** ch2 score 2048+37, id 5, `vld` held 10 cycles → exactly one output {5, 37} at latency 2; `count`=1; `max_score`=37, `max_id`=5.
- **All channels at once:** all 8 channels valid in the same cycle, ids 0–7, scores 10..17 → 8 outputs in order 0..7 on consecutive cycles; `max_score`=17, `max_id`=7.
- **Threshold and backpressure:** `threshold`=20; scores {5, 25, 20, −3}; `out_ready` low until 4 grants have occurred → outputs {25, 20} only; `count`=4; `max_score`=25.
- **FIFO full stall:** DEPTH=16; 20 results with `out_ready`=0 → `out_valid` high, 4 entries still pending. Release `out_ready` → all 20 delivered, none lost, `overrun`=0.
- **Clear with held results:** `clr` pulse while ch1 `vld` is held → no recapture; `count`=0, `max_vld`=0. A fresh ch1 rise after `vld` drops → captured.
- **Lost result and reset:** ch0 pulses twice while its first result is pending and the FIFO is full → `overrun`=1. Async `rst` mid-burst → all outputs 0 immediately.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared definitions for the scoring bank result path: score bias,
// unbiasing helper and the {id, score} result record.
package sw_pkg;

    localparam int unsigned SW_SCORE_WIDTH = 12;
    localparam int unsigned SW_ID_WIDTH    = 48;
    localparam int unsigned SW_ZERO        = 2**(SW_SCORE_WIDTH-1);

    typedef struct packed {
        logic [SW_ID_WIDTH-1:0]    id;
        logic [SW_SCORE_WIDTH-1:0] score;
    } result_t;

    // Remove the bias from a score. Callers truncate back to their score
    // width, so the result is the two's complement value with no growth.
    function automatic logic [31:0] unbias(input logic [31:0] score,
                                           input logic [31:0] bias);
        return score - bias;
    endfunction

endpackage

// File: rtl/score_collector_if.sv
// Bank-facing result bus and host-facing valid/ready result stream.
// master: the side that owns results/IDs/vld and consumes the stream.
// slave:  the collector.
interface score_collector_if #(
    parameter int unsigned SCORE_WIDTH = 12,
    parameter int unsigned ID_WIDTH    = 48,
    parameter int unsigned CHANNELS    = 8
);

    logic [0:CHANNELS*SCORE_WIDTH-1] results;
    logic [0:CHANNELS*ID_WIDTH-1]    IDs;
    logic [0:CHANNELS-1]             vld;

    logic                            out_valid;
    logic                            out_ready;
    logic [ID_WIDTH-1:0]             out_id;
    logic [SCORE_WIDTH-1:0]          out_score;

    modport master (
        output results, IDs, vld, out_ready,
        input  out_valid, out_id, out_score
    );

    modport slave (
        input  results, IDs, vld, out_ready,
        output out_valid, out_id, out_score
    );

endinterface

// File: rtl/score_fifo.sv
// Show-ahead FIFO: the head entry is visible on pop_data_o whenever the
// FIFO is non-empty (zero otherwise). Synchronous flush has priority.
module score_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !full_q && !flush_i;
    assign do_pop  = pop_i && !empty_q && !flush_i;

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Pointers, occupancy and registered full/empty flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == (AW+1)'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    // Storage array; contents are only observable through a valid head.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = empty_q ? '0 : mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;

endmodule

// File: rtl/score_collector.sv
// Result collector behind a scoring bank: captures each new valid result
// once per channel, arbitrates round-robin into a show-ahead FIFO, keeps
// the per-query maximum and a saturating result count.
module score_collector
    import sw_pkg::*;
#(
    parameter int unsigned SCORE_WIDTH = 12,
    parameter int unsigned ID_WIDTH    = 48,
    parameter int unsigned CHANNELS    = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned ZERO        = 2**(SCORE_WIDTH-1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic [SCORE_WIDTH-1:0] threshold,
    score_collector_if.slave       bus,
    output logic [SCORE_WIDTH-1:0] max_score,
    output logic [ID_WIDTH-1:0]    max_id,
    output logic                   max_vld,
    output logic [CNT_WIDTH-1:0]   count,
    output logic                   overrun
);

    localparam int unsigned IDX_W   = $clog2(CHANNELS);
    localparam int unsigned ENTRY_W = ID_WIDTH + SCORE_WIDTH;

    logic [CHANNELS-1:0]    vld_vec;
    logic [CHANNELS-1:0]    vld_prev_q;
    logic [CHANNELS-1:0]    armed_q;
    logic [CHANNELS-1:0]    armed_d;
    logic [CHANNELS-1:0]    pending_q;
    logic [CHANNELS-1:0]    pending_d;
    logic [CHANNELS-1:0]    capture;
    logic                   lost;
    logic [SCORE_WIDTH-1:0] hold_score_q [CHANNELS];
    logic [ID_WIDTH-1:0]    hold_id_q    [CHANNELS];

    logic [IDX_W-1:0]       rr_q;
    logic [IDX_W-1:0]       rr_d;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant;
    int unsigned            scan_idx;
    logic [SCORE_WIDTH-1:0] grant_score;
    logic [ID_WIDTH-1:0]    grant_id;

    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [ENTRY_W-1:0]     head;

    logic [SCORE_WIDTH-1:0] max_score_q;
    logic [ID_WIDTH-1:0]    max_id_q;
    logic                   max_vld_q;
    logic [CNT_WIDTH-1:0]   count_q;
    logic                   overrun_q;

    // Reorder the ascending-indexed valid bus into a plain channel vector.
    always_comb begin
        vld_vec = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            vld_vec[c] = bus.vld[c];
        end
    end

    // Per-channel capture/arm/pending bookkeeping and lost-result detection.
    // A rise seen while pending leaves armed set, so it is captured once the
    // slot frees; if vld drops first with armed still set, the result is lost.
    always_comb begin
        armed_d   = armed_q;
        pending_d = pending_q;
        capture   = '0;
        lost      = 1'b0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (vld_vec[c] && armed_q[c] && !pending_q[c]) begin
                capture[c]   = 1'b1;
                pending_d[c] = 1'b1;
                armed_d[c]   = 1'b0;
            end
            if (!vld_vec[c]) armed_d[c] = 1'b1;
            if (!vld_vec[c] && vld_prev_q[c] && armed_q[c]) lost = 1'b1;
        end
        if (grant) pending_d[grant_idx] = 1'b0;
        if (clr) begin
            capture   = '0;
            pending_d = '0;
            armed_d   = ~vld_vec;
        end
    end

    // Channel state registers and holding registers (score stored unbiased).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_q    <= '1;
            pending_q  <= '0;
            vld_prev_q <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                hold_score_q[c] <= '0;
                hold_id_q[c]    <= '0;
            end
        end else begin
            armed_q    <= armed_d;
            pending_q  <= pending_d;
            vld_prev_q <= vld_vec;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (capture[c]) begin
                    hold_score_q[c] <= SCORE_WIDTH'(unbias(
                        32'(bus.results[c*SCORE_WIDTH +: SCORE_WIDTH]), 32'(ZERO)));
                    hold_id_q[c]    <= bus.IDs[c*ID_WIDTH +: ID_WIDTH];
                end
            end
        end
    end

    // Round-robin search from the channel after the last grant; stalls on
    // registered full and is suppressed by clr.
    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            scan_idx = (32'(rr_q) + i) % CHANNELS;
            if (!grant && pending_q[IDX_W'(scan_idx)]) begin
                grant     = 1'b1;
                grant_idx = IDX_W'(scan_idx);
            end
        end
        if (fifo_full || clr) grant = 1'b0;
    end

    // Next search start: one past the granted channel, wrapping.
    always_comb begin
        rr_d = rr_q;
        if (clr) begin
            rr_d = '0;
        end else if (grant) begin
            rr_d = (grant_idx == IDX_W'(CHANNELS-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rr_q <= '0;
        else      rr_q <= rr_d;
    end

    assign grant_score = hold_score_q[grant_idx];
    assign grant_id    = hold_id_q[grant_idx];
    assign push        = grant && ($signed(grant_score) >= $signed(threshold));
    assign pop         = !fifo_empty && bus.out_ready && !clr;

    // Query statistics: saturating count, running max (ties keep earlier),
    // sticky overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_score_q <= '0;
            max_id_q    <= '0;
            max_vld_q   <= 1'b0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
        end else if (clr) begin
            max_score_q <= '0;
            max_id_q    <= '0;
            max_vld_q   <= 1'b0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
        end else begin
            if (lost) overrun_q <= 1'b1;
            if (grant) begin
                if (count_q != '1) count_q <= count_q + 1'b1;
                if (!max_vld_q || ($signed(grant_score) > $signed(max_score_q))) begin
                    max_score_q <= grant_score;
                    max_id_q    <= grant_id;
                    max_vld_q   <= 1'b1;
                end
            end
        end
    end

    score_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (clr),
        .push_i      (push),
        .push_data_i ({grant_id, grant_score}),
        .pop_i       (pop),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_id    = head[ENTRY_W-1 -: ID_WIDTH];
    assign bus.out_score = head[SCORE_WIDTH-1:0];

    assign max_score = max_score_q;
    assign max_id    = max_id_q;
    assign max_vld   = max_vld_q;
    assign count     = count_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_score_collector.sv
// Directed bench for score_collector: one task per scenario, inline checks.
`timescale 1ns/1ps
module tb_score_collector;
    import sw_pkg::*;

    localparam int unsigned SW = 12;
    localparam int unsigned IW = 48;
    localparam int unsigned CH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic [SW-1:0] threshold;
    logic [SW-1:0] max_score;
    logic [IW-1:0] max_id;
    logic          max_vld;
    logic [15:0]   count;
    logic          overrun;

    score_collector_if #(.SCORE_WIDTH(SW), .ID_WIDTH(IW), .CHANNELS(CH)) bus ();

    score_collector #(
        .SCORE_WIDTH (SW),
        .ID_WIDTH    (IW),
        .CHANNELS    (CH),
        .DEPTH       (16),
        .CNT_WIDTH   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .threshold (threshold),
        .bus       (bus),
        .max_score (max_score),
        .max_id    (max_id),
        .max_vld   (max_vld),
        .count     (count),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int      tests_run    = 0;
    int      tests_failed = 0;
    int      cyc          = 0;
    result_t got_q[$];
    int      cyc_q[$];

    // One clock: log the head if it will be accepted at this edge, then
    // advance to 1ns after the rising edge.
    task automatic step();
        result_t r;
        if (rst && !clr && bus.out_valid && bus.out_ready) begin
            r.id    = bus.out_id;
            r.score = bus.out_score;
            got_q.push_back(r);
            cyc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_ch(input int c, input logic [IW-1:0] id, input int s);
        bus.IDs[c*IW +: IW]     = id;
        bus.results[c*SW +: SW] = SW'(int'(SW_ZERO) + s);
        bus.vld[c]              = 1'b1;
    endtask

    task automatic clear_query();
        clr = 1'b1;
        step();
        clr = 1'b0;
        got_q.delete();
        cyc_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %0d expected 0", bus.out_valid); end
        tests_run++; if (bus.out_id !== '0) begin tests_failed++; $display("FAIL reset_out_id: got %0d expected 0", bus.out_id); end
        tests_run++; if (bus.out_score !== '0) begin tests_failed++; $display("FAIL reset_out_score: got %0d expected 0", bus.out_score); end
        tests_run++; if (max_score !== '0) begin tests_failed++; $display("FAIL reset_max_score: got %0d expected 0", max_score); end
        tests_run++; if (max_id !== '0) begin tests_failed++; $display("FAIL reset_max_id: got %0d expected 0", max_id); end
        tests_run++; if (max_vld !== 1'b0) begin tests_failed++; $display("FAIL reset_max_vld: got %0d expected 0", max_vld); end
        tests_run++; if (count !== '0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", count); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %0d expected 0", overrun); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        clear_query();
        bus.out_ready = 1'b1;
        set_ch(2, 48'd5, 37);
        step();
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_latency_early: got %0d expected 0", bus.out_valid); end
        step();
        tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL single_latency2_valid: got %0d expected 1", bus.out_valid); end
        tests_run++; if (bus.out_id !== 48'd5) begin tests_failed++; $display("FAIL single_head_id: got %0d expected 5", bus.out_id); end
        tests_run++; if (bus.out_score !== 12'd37) begin tests_failed++; $display("FAIL single_head_score: got %0d expected 37", $signed(bus.out_score)); end
        steps(8);
        bus.vld = '0;
        steps(4);
        tests_run++; if (got_q.size() != 1) begin tests_failed++; $display("FAIL single_num_outputs: got %0d expected 1", got_q.size()); end
        tests_run++; if (count !== 16'd1) begin tests_failed++; $display("FAIL single_count: got %0d expected 1", count); end
        tests_run++; if (max_score !== 12'd37) begin tests_failed++; $display("FAIL single_max_score: got %0d expected 37", $signed(max_score)); end
        tests_run++; if (max_id !== 48'd5) begin tests_failed++; $display("FAIL single_max_id: got %0d expected 5", max_id); end
        tests_run++; if (max_vld !== 1'b1) begin tests_failed++; $display("FAIL single_max_vld: got %0d expected 1", max_vld); end
    endtask

    task automatic test_all_channels();
        clear_query();
        bus.out_ready = 1'b1;
        for (int c = 0; c < int'(CH); c++) set_ch(c, IW'(c), 10 + c);
        steps(12);
        bus.vld = '0;
        steps(2);
        tests_run++; if (got_q.size() != 8) begin tests_failed++; $display("FAIL all_num_outputs: got %0d expected 8", got_q.size()); end
        if (got_q.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                tests_run++; if (got_q[i].id !== IW'(i)) begin tests_failed++; $display("FAIL all_order_id[%0d]: got %0d expected %0d", i, got_q[i].id, i); end
                tests_run++; if (got_q[i].score !== SW'(10 + i)) begin tests_failed++; $display("FAIL all_score[%0d]: got %0d expected %0d", i, got_q[i].score, 10 + i); end
                if (i > 0) begin
                    tests_run++; if (cyc_q[i] != cyc_q[i-1] + 1) begin tests_failed++; $display("FAIL all_back_to_back[%0d]: got gap %0d expected 1", i, cyc_q[i] - cyc_q[i-1]); end
                end
            end
        end
        tests_run++; if (max_score !== 12'd17) begin tests_failed++; $display("FAIL all_max_score: got %0d expected 17", $signed(max_score)); end
        tests_run++; if (max_id !== 48'd7) begin tests_failed++; $display("FAIL all_max_id: got %0d expected 7", max_id); end
        tests_run++; if (count !== 16'd8) begin tests_failed++; $display("FAIL all_count: got %0d expected 8", count); end
    endtask

    task automatic test_threshold_backpressure();
        clear_query();
        threshold     = 12'd20;
        bus.out_ready = 1'b0;
        set_ch(0, 48'd100, 5);
        set_ch(1, 48'd101, 25);
        set_ch(2, 48'd102, 20);
        set_ch(3, 48'd103, -3);
        steps(6);
        tests_run++; if (count !== 16'd4) begin tests_failed++; $display("FAIL thr_count: got %0d expected 4", count); end
        tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL thr_valid_held: got %0d expected 1", bus.out_valid); end
        steps(3);
        tests_run++; if (bus.out_id !== 48'd101) begin tests_failed++; $display("FAIL thr_head_stable_id: got %0d expected 101", bus.out_id); end
        tests_run++; if (bus.out_score !== 12'd25) begin tests_failed++; $display("FAIL thr_head_stable_score: got %0d expected 25", $signed(bus.out_score)); end
        bus.out_ready = 1'b1;
        steps(4);
        bus.vld = '0;
        steps(2);
        tests_run++; if (got_q.size() != 2) begin tests_failed++; $display("FAIL thr_num_outputs: got %0d expected 2", got_q.size()); end
        if (got_q.size() == 2) begin
            tests_run++; if (got_q[0].id !== 48'd101 || got_q[0].score !== 12'd25) begin tests_failed++; $display("FAIL thr_out0: got {%0d,%0d} expected {101,25}", got_q[0].id, got_q[0].score); end
            tests_run++; if (got_q[1].id !== 48'd102 || got_q[1].score !== 12'd20) begin tests_failed++; $display("FAIL thr_out1: got {%0d,%0d} expected {102,20}", got_q[1].id, got_q[1].score); end
        end
        tests_run++; if (max_score !== 12'd25) begin tests_failed++; $display("FAIL thr_max_score: got %0d expected 25", $signed(max_score)); end
        tests_run++; if (max_id !== 48'd101) begin tests_failed++; $display("FAIL thr_max_id: got %0d expected 101", max_id); end
        threshold = 12'h800;
    endtask

    task automatic test_fifo_full();
        clear_query();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 8; c++) set_ch(c, IW'(200 + c), c);
        steps(10);
        bus.vld = '0;
        step();
        for (int c = 0; c < 8; c++) set_ch(c, IW'(208 + c), 8 + c);
        steps(10);
        bus.vld = '0;
        step();
        for (int c = 0; c < 4; c++) set_ch(c, IW'(216 + c), 16 + c);
        steps(6);
        tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL full_valid: got %0d expected 1", bus.out_valid); end
        tests_run++; if (count !== 16'd16) begin tests_failed++; $display("FAIL full_stalled_count: got %0d expected 16", count); end
        tests_run++; if (bus.out_id !== 48'd200) begin tests_failed++; $display("FAIL full_head_id: got %0d expected 200", bus.out_id); end
        bus.out_ready = 1'b1;
        steps(30);
        bus.vld = '0;
        steps(3);
        tests_run++; if (got_q.size() != 20) begin tests_failed++; $display("FAIL full_num_outputs: got %0d expected 20", got_q.size()); end
        if (got_q.size() == 20) begin
            for (int i = 0; i < 20; i++) begin
                tests_run++; if (got_q[i].id !== IW'(200 + i) || got_q[i].score !== SW'(i)) begin tests_failed++; $display("FAIL full_out[%0d]: got {%0d,%0d} expected {%0d,%0d}", i, got_q[i].id, got_q[i].score, 200 + i, i); end
            end
        end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL full_overrun: got %0d expected 0", overrun); end
        tests_run++; if (count !== 16'd20) begin tests_failed++; $display("FAIL full_count: got %0d expected 20", count); end
        tests_run++; if (max_id !== 48'd219) begin tests_failed++; $display("FAIL full_max_id: got %0d expected 219", max_id); end
    endtask

    task automatic test_clear_held();
        clear_query();
        bus.out_ready = 1'b1;
        set_ch(1, 48'd300, 50);
        steps(5);
        tests_run++; if (got_q.size() != 1) begin tests_failed++; $display("FAIL clr_first_capture: got %0d outputs expected 1", got_q.size()); end
        got_q.delete();
        clr = 1'b1;
        step();
        clr = 1'b0;
        steps(5);
        tests_run++; if (got_q.size() != 0) begin tests_failed++; $display("FAIL clr_no_recapture: got %0d outputs expected 0", got_q.size()); end
        tests_run++; if (count !== 16'd0) begin tests_failed++; $display("FAIL clr_count: got %0d expected 0", count); end
        tests_run++; if (max_vld !== 1'b0) begin tests_failed++; $display("FAIL clr_max_vld: got %0d expected 0", max_vld); end
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL clr_out_valid: got %0d expected 0", bus.out_valid); end
        bus.vld[1] = 1'b0;
        steps(2);
        set_ch(1, 48'd301, 60);
        steps(4);
        tests_run++; if (got_q.size() != 1) begin tests_failed++; $display("FAIL clr_fresh_rise: got %0d outputs expected 1", got_q.size()); end
        if (got_q.size() == 1) begin
            tests_run++; if (got_q[0].id !== 48'd301 || got_q[0].score !== 12'd60) begin tests_failed++; $display("FAIL clr_fresh_value: got {%0d,%0d} expected {301,60}", got_q[0].id, got_q[0].score); end
        end
        tests_run++; if (count !== 16'd1) begin tests_failed++; $display("FAIL clr_fresh_count: got %0d expected 1", count); end
        bus.vld = '0;
        step();
    endtask

    task automatic test_overrun_reset();
        clear_query();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 8; c++) set_ch(c, IW'(500 + c), c + 1);
        steps(10);
        bus.vld = '0;
        step();
        for (int c = 0; c < 8; c++) set_ch(c, IW'(508 + c), c + 9);
        steps(10);
        bus.vld = '0;
        step();
        set_ch(0, 48'd600, 1);
        step();
        bus.vld[0] = 1'b0;
        step();
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_before: got %0d expected 0", overrun); end
        set_ch(0, 48'd601, 2);
        step();
        bus.vld[0] = 1'b0;
        step();
        tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_after_lost: got %0d expected 1", overrun); end
        tests_run++; if (count !== 16'd16) begin tests_failed++; $display("FAIL ovr_count: got %0d expected 16", count); end
        tests_run++; if (max_score !== 12'd16) begin tests_failed++; $display("FAIL ovr_max_score: got %0d expected 16", $signed(max_score)); end
        for (int c = 0; c < 8; c++) set_ch(c, IW'(700 + c), 3);
        step();
        #3;
        rst = 1'b0;
        #1;
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL arst_out_valid: got %0d expected 0", bus.out_valid); end
        tests_run++; if (bus.out_id !== '0 || bus.out_score !== '0) begin tests_failed++; $display("FAIL arst_out_data: got {%0d,%0d} expected {0,0}", bus.out_id, bus.out_score); end
        tests_run++; if (max_score !== '0 || max_id !== '0 || max_vld !== 1'b0) begin tests_failed++; $display("FAIL arst_max: got {%0d,%0d,%0d} expected {0,0,0}", max_score, max_id, max_vld); end
        tests_run++; if (count !== '0) begin tests_failed++; $display("FAIL arst_count: got %0d expected 0", count); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL arst_overrun: got %0d expected 0", overrun); end
        bus.vld       = '0;
        bus.out_ready = 1'b1;
        steps(2);
        rst = 1'b1;
        steps(4);
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL arst_release_valid: got %0d expected 0", bus.out_valid); end
        tests_run++; if (count !== '0) begin tests_failed++; $display("FAIL arst_release_count: got %0d expected 0", count); end
    endtask

    initial begin
        bus.results   = '0;
        bus.IDs       = '0;
        bus.vld       = '0;
        bus.out_ready = 1'b0;
        threshold     = 12'h800;
        test_reset();
        test_single();
        test_all_channels();
        test_threshold_backpressure();
        test_fifo_full();
        test_clear_held();
        test_overrun_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

endmodule
